// File: rtl/stream_fifo_16.sv
// Single-clock first-word-fall-through stream FIFO with an advisory
// almost-full output and a sticky overflow flag for the non-stallable source.
module stream_fifo_16 #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       i_fifo,
  input  logic                   srdyi_fifo,
  output logic                   drdyo_fifo,
  output logic [WIDTH-1:0]       o_fifo,
  output logic                   srdyo_fifo,
  input  logic                   drdyi_fifo,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LVL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = ~w_empty & drdyi_fifo;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_push  = srdyi_fifo & (~w_full | w_pop);
  assign w_drop  = srdyi_fifo & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wp] <= i_fifo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Gating on empty keeps stale storage from ever reaching the output.
  assign o_fifo     = w_empty ? '0 : r_mem[r_rp];
  assign srdyo_fifo = ~w_empty;
  assign drdyo_fifo = (r_count < C_AFULL);
  assign count      = r_count;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_stream_fifo_16.sv
// Directed bench for stream_fifo_16: stimulus queues expected words into a
// scoreboard and a negedge monitor checks every popped word against it.
module tb_stream_fifo_16;

  logic        clk;
  logic        rst;
  logic [31:0] i_fifo;
  logic        srdyi_fifo;
  logic        drdyo_fifo;
  logic [31:0] o_fifo;
  logic        srdyo_fifo;
  logic        drdyi_fifo;
  logic [4:0]  count;
  logic        ovf;

  int          vectors;
  int          miscompares;
  int          mCount;
  logic [31:0] sbQ[$];

  stream_fifo_16 #(.WIDTH(32), .DEPTH(16), .AFULL_LVL(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_fifo     (i_fifo),
    .srdyi_fifo (srdyi_fifo),
    .drdyo_fifo (drdyo_fifo),
    .o_fifo     (o_fifo),
    .srdyo_fifo (srdyo_fifo),
    .drdyi_fifo (drdyi_fifo),
    .count      (count),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; words the queue will accept go to the scoreboard.
  task automatic applyStimulus(input bit push, input logic [31:0] data, input bit pop);
    bit popOcc;
    bit pushOcc;
    srdyi_fifo = push;
    i_fifo     = data;
    drdyi_fifo = pop;
    popOcc  = pop && (mCount > 0);
    pushOcc = push && ((mCount < 16) || popOcc);
    if (pushOcc) sbQ.push_back(data);
    mCount = mCount + (pushOcc ? 1 : 0) - (popOcc ? 1 : 0);
    @(posedge clk);
    #1;
    srdyi_fifo = 1'b0;
    drdyi_fifo = 1'b0;
  endtask

  task automatic doReset(input bit push, input logic [31:0] data);
    rst        = 1'b1;
    srdyi_fifo = push;
    i_fifo     = data;
    drdyi_fifo = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    srdyi_fifo = 1'b0;
    sbQ.delete();
    mCount = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && srdyo_fifo && drdyi_fifo) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedPop", o_fifo, 32'hxxxx_xxxx);
      end else begin
        checkOutput("popData", o_fifo, sbQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mCount      = 0;
    rst         = 1'b0;
    i_fifo      = '0;
    srdyi_fifo  = 1'b0;
    drdyi_fifo  = 1'b0;

    doReset(1'b0, 32'h0);
    doReset(1'b0, 32'h0);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstSrdyo", 32'(srdyo_fifo), 32'd0);
    checkOutput("rstDrdyo", 32'(drdyo_fifo), 32'd1);
    checkOutput("rstOfifo", o_fifo, 32'h0);
    checkOutput("rstOvf", 32'(ovf), 32'd0);

    // Three pushes without popping, head visible the cycle after the first
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      checkOutput("fillCount", 32'(count), 32'(i));
      checkOutput("fillHead", o_fifo, 32'h1);
      checkOutput("fillSrdyo", 32'(srdyo_fifo), 32'd1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("drainCount", 32'(count), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("emptyPopCount", 32'(count), 32'd0);
    checkOutput("emptyOfifo", o_fifo, 32'h0);

    // Overflow: 16 words then a dropped 0xFF
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0);
    checkOutput("fullCount", 32'(count), 32'd16);
    checkOutput("fullDrdyo", 32'(drdyo_fifo), 32'd0);
    checkOutput("fullOvfPre", 32'(ovf), 32'd0);
    applyStimulus(1'b1, 32'hFF, 1'b0);
    checkOutput("ovfCount", 32'(count), 32'd16);
    checkOutput("ovfSet", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("ovfDrainCount", 32'(count), 32'd0);
    checkOutput("ovfSticky", 32'(ovf), 32'd1);
    doReset(1'b0, 32'h0);
    checkOutput("ovfCleared", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'hB0, 1'b1);
    checkOutput("fullPushPopCount", 32'(count), 32'd16);
    checkOutput("fullPushPopOvf", 32'(ovf), 32'd0);
    checkOutput("fullPushPopHead", o_fifo, 32'hC1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("b0DrainCount", 32'(count), 32'd0);

    // Continuous streaming across pointer wrap
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1);
    checkOutput("streamCount", 32'(count), 32'd1);
    checkOutput("streamHead", o_fifo, 32'h127);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("streamEndCount", 32'(count), 32'd0);

    // Almost-full advisory threshold
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0);
    checkOutput("afull11", 32'(drdyo_fifo), 32'd1);
    applyStimulus(1'b1, 32'h20B, 1'b0);
    checkOutput("afull12", 32'(drdyo_fifo), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("afullPopCount", 32'(count), 32'd11);
    checkOutput("afullPopDrdyo", 32'(drdyo_fifo), 32'd1);
    applyStimulus(1'b1, 32'h20C, 1'b0);
    applyStimulus(1'b1, 32'h20D, 1'b0);
    checkOutput("advisoryPush", 32'(count), 32'd13);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("preRstCount", 32'(count), 32'd9);

    // Reset wins over a pending push
    doReset(1'b1, 32'hDEAD);
    checkOutput("midRstCount", 32'(count), 32'd0);
    checkOutput("midRstSrdyo", 32'(srdyo_fifo), 32'd0);
    checkOutput("midRstOvf", 32'(ovf), 32'd0);
    checkOutput("midRstOfifo", o_fifo, 32'h0);
    applyStimulus(1'b1, 32'h55, 1'b0);
    checkOutput("postRstCount", 32'(count), 32'd1);
    checkOutput("postRstHead", o_fifo, 32'h55);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("finalCount", 32'(count), 32'd0);

    @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
